// File: rtl/best_disp_select_if.sv
// Candidate/result bundle between the correlation accumulator and the best-disparity selector.
// The master side drives the candidates, and the slave side (the selector) reports the best match.
interface best_disp_select_if;
    logic        frame_start;
    logic [10:0] fsum;
    logic        valid;
    logic        last;
    logic [13:0] g2sum;
    logic [10:0] gsum;
    logic [13:0] fg;
    logic [5:0]  place;
    logic        busy;
    logic [5:0]  best_place;
    logic        best_valid;
    logic        done;
    logic        overrun;

    modport master (
        output frame_start, fsum, valid, last, g2sum, gsum, fg, place,
        input  busy, best_place, best_valid, done, overrun
    );

    modport slave (
        input  frame_start, fsum, valid, last, g2sum, gsum, fg, place,
        output busy, best_place, best_valid, done, overrun
    );
endinterface

// File: rtl/best_disp_select.sv
// Scores each candidate offset with a division-free normalized correlation (num^2/den),
// using one shared multiplier, and keeps the best place seen during the current matching frame.
module best_disp_select #(
    parameter int unsigned NPIX_LOG2 = 8
) (
    input  logic               clk,
    input  logic               rst,
    best_disp_select_if.slave  bus
);
    typedef enum logic [2:0] {
        S_IDLE,
        S_M1,
        S_M2,
        S_M3,
        S_M4,
        S_M5,
        S_UPD
    } state_t;

    state_t      r_state;
    logic [10:0] r_fsum;
    logic [10:0] r_gsum;
    logic [13:0] r_fg;
    logic [13:0] r_g2sum;
    logic [5:0]  r_place;
    logic        r_last;
    logic [22:0] r_num;
    logic [22:0] r_den;
    logic [43:0] r_sq_c;
    logic [65:0] r_p4;
    logic [65:0] r_p5;
    logic [43:0] r_sq_b;
    logic [22:0] r_den_b;
    logic        r_busy;
    logic [5:0]  r_best_place;
    logic        r_best_valid;
    logic        r_done;
    logic        r_overrun;

    logic [43:0] w_mul_a;
    logic [22:0] w_mul_b;
    logic [65:0] w_prod;
    logic [22:0] w_fg_sh;
    logic [22:0] w_g2_sh;
    logic        w_accept;
    logic        w_eligible;

    assign w_fg_sh    = 23'(r_fg) << NPIX_LOG2;
    assign w_g2_sh    = 23'(r_g2sum) << NPIX_LOG2;
    assign w_accept   = bus.valid && (bus.frame_start || r_state == S_IDLE);
    assign w_eligible = !r_num[22] && (|r_num) && !r_den[22] && (|r_den);

    // Operands of the single shared multiplier. Once eligibility holds, num and den are
    // positive and below 2^22, so their low 22 bits carry the full magnitude.
    always_comb begin
        w_mul_a = '0;
        w_mul_b = '0;
        case (r_state)
            S_M1: begin
                w_mul_a = 44'(r_fsum);
                w_mul_b = 23'(r_gsum);
            end
            S_M2: begin
                w_mul_a = 44'(r_gsum);
                w_mul_b = 23'(r_gsum);
            end
            S_M3: begin
                w_mul_a = 44'(r_num[21:0]);
                w_mul_b = {1'b0, r_num[21:0]};
            end
            S_M4: begin
                w_mul_a = r_sq_c;
                w_mul_b = r_den_b;
            end
            S_M5: begin
                w_mul_a = r_sq_b;
                w_mul_b = r_den;
            end
            default: begin
                w_mul_a = '0;
                w_mul_b = '0;
            end
        endcase
    end

    assign w_prod = {22'b0, w_mul_a} * {43'b0, w_mul_b};

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_fsum       <= '0;
            r_gsum       <= '0;
            r_fg         <= '0;
            r_g2sum      <= '0;
            r_place      <= '0;
            r_last       <= 1'b0;
            r_num        <= '0;
            r_den        <= '0;
            r_sq_c       <= '0;
            r_p4         <= '0;
            r_p5         <= '0;
            r_sq_b       <= '0;
            r_den_b      <= '0;
            r_busy       <= 1'b0;
            r_best_place <= '0;
            r_best_valid <= 1'b0;
            r_done       <= 1'b0;
            r_overrun    <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (w_accept) begin
                r_fsum  <= bus.fsum;
                r_gsum  <= bus.gsum;
                r_fg    <= bus.fg;
                r_g2sum <= bus.g2sum;
                r_place <= bus.place;
                r_last  <= bus.last;
            end
            if (bus.frame_start) begin
                r_best_place <= '0;
                r_best_valid <= 1'b0;
                r_sq_b       <= '0;
                r_den_b      <= '0;
                r_overrun    <= 1'b0;
                r_busy       <= bus.valid;
                r_state      <= bus.valid ? S_M1 : S_IDLE;
            end else begin
                if (bus.valid && r_state != S_IDLE)
                    r_overrun <= 1'b1;
                case (r_state)
                    S_IDLE: begin
                        if (bus.valid) begin
                            r_busy  <= 1'b1;
                            r_state <= S_M1;
                        end
                    end
                    S_M1: begin
                        r_num   <= w_fg_sh - 23'(w_prod[21:0]);
                        r_state <= S_M2;
                    end
                    S_M2: begin
                        r_den   <= w_g2_sh - 23'(w_prod[21:0]);
                        r_state <= S_M3;
                    end
                    S_M3: begin
                        r_sq_c  <= w_prod[43:0];
                        r_state <= S_M4;
                    end
                    S_M4: begin
                        r_p4    <= w_prod;
                        r_state <= S_M5;
                    end
                    S_M5: begin
                        r_p5    <= w_prod;
                        r_state <= S_UPD;
                    end
                    S_UPD: begin
                        // Strict compare keeps the earlier candidate on a tie.
                        if (w_eligible && (!r_best_valid || r_p4 > r_p5)) begin
                            r_best_place <= r_place;
                            r_sq_b       <= r_sq_c;
                            r_den_b      <= r_den;
                            r_best_valid <= 1'b1;
                        end
                        r_done  <= r_last;
                        r_busy  <= 1'b0;
                        r_state <= S_IDLE;
                    end
                    default: begin
                        r_busy  <= 1'b0;
                        r_state <= S_IDLE;
                    end
                endcase
            end
        end
    end

    assign bus.busy       = r_busy;
    assign bus.best_place = r_best_place;
    assign bus.best_valid = r_best_valid;
    assign bus.done       = r_done;
    assign bus.overrun    = r_overrun;
endmodule

// File: tb/tb_best_disp_select.sv
// Directed bench for best_disp_select: the expected result of each candidate goes into a queue,
// and a monitor compares that result whenever busy falls.
module tb_best_disp_select;
    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    best_disp_select_if bus();

    best_disp_select #(.NPIX_LOG2(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic [5:0] place;
        logic       valid;
        logic       done;
    } exp_t;

    exp_t q[$];
    exp_t mon_e;
    int   checks = 0;
    int   errors = 0;
    logic prev_busy = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Scoreboard monitor: a falling busy marks a finished or aborted candidate.
    initial begin
        forever begin
            @(negedge clk);
            if (prev_busy === 1'b1 && bus.busy === 1'b0) begin
                if (q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_completion: got busy fall expected none at %0t", $time);
                end else begin
                    mon_e = q.pop_front();
                    chk("mon_best_place", 64'(bus.best_place), 64'(mon_e.place));
                    chk("mon_best_valid", 64'(bus.best_valid), 64'(mon_e.valid));
                    chk("mon_done", 64'(bus.done), 64'(mon_e.done));
                end
            end
            prev_busy = bus.busy;
        end
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish expected finish at %0t", $time);
        $fatal(1, "timeout");
    end

    task automatic push_exp(input logic [5:0] p, input logic v, input logic d);
        exp_t e;
        e.place = p;
        e.valid = v;
        e.done  = d;
        q.push_back(e);
    endtask

    task automatic frame();
        bus.frame_start = 1'b1;
        @(posedge clk); #1;
        bus.frame_start = 1'b0;
    endtask

    task automatic launch(input logic [10:0] fs, input logic [10:0] gs, input logic [13:0] f,
                          input logic [13:0] g2, input logic [5:0] pl, input logic ls);
        bus.fsum  = fs;
        bus.gsum  = gs;
        bus.fg    = f;
        bus.g2sum = g2;
        bus.place = pl;
        bus.last  = ls;
        bus.valid = 1'b1;
        @(posedge clk); #1;
        bus.valid = 1'b0;
        bus.last  = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (bus.busy === 1'b1 && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        chk("wait_idle", 64'(bus.busy), 64'd0);
    endtask

    // Full candidate with busy timing: high after T and T+5, low after T+6.
    task automatic send(input logic [10:0] fs, input logic [10:0] gs, input logic [13:0] f,
                        input logic [13:0] g2, input logic [5:0] pl, input logic ls,
                        input logic [5:0] ep, input logic ev, input logic ed);
        push_exp(ep, ev, ed);
        launch(fs, gs, f, g2, pl, ls);
        chk("busy_start", 64'(bus.busy), 64'd1);
        repeat (5) begin
            @(posedge clk); #1;
        end
        chk("busy_hold", 64'(bus.busy), 64'd1);
        @(posedge clk); #1;
        chk("busy_end", 64'(bus.busy), 64'd0);
    endtask

    initial begin
        rst             = 1'b1;
        bus.frame_start = 1'b0;
        bus.fsum        = '0;
        bus.valid       = 1'b0;
        bus.last        = 1'b0;
        bus.g2sum       = '0;
        bus.gsum        = '0;
        bus.fg          = '0;
        bus.place       = '0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        chk("rst_busy", 64'(bus.busy), 64'd0);
        chk("rst_best_place", 64'(bus.best_place), 64'd0);
        chk("rst_best_valid", 64'(bus.best_valid), 64'd0);
        chk("rst_done", 64'(bus.done), 64'd0);
        chk("rst_overrun", 64'(bus.overrun), 64'd0);

        // A: num=den=45056 wins by default; B: score ~3106 loses, ends the frame.
        frame();
        send(11'd512, 11'd512, 14'd1200, 14'd1200, 6'd5, 1'b0, 6'd5, 1'b1, 1'b0);
        send(11'd512, 11'd512, 14'd1100, 14'd1500, 6'd9, 1'b1, 6'd5, 1'b1, 1'b1);
        @(posedge clk); #1;
        chk("done_one_cycle", 64'(bus.done), 64'd0);
        chk("hold_best_place", 64'(bus.best_place), 64'd5);

        // Ineligible: negative num, then zero den.
        frame();
        send(11'd512, 11'd512, 14'd1000, 14'd1200, 6'd11, 1'b1, 6'd0, 1'b0, 1'b1);
        frame();
        send(11'd512, 11'd512, 14'd1200, 14'd1024, 6'd13, 1'b1, 6'd0, 1'b0, 1'b1);

        // Tie keeps place 5; stronger C (num=den=70656) then wins.
        frame();
        send(11'd512, 11'd512, 14'd1200, 14'd1200, 6'd5, 1'b0, 6'd5, 1'b1, 1'b0);
        send(11'd512, 11'd512, 14'd1200, 14'd1200, 6'd12, 1'b0, 6'd5, 1'b1, 1'b0);
        send(11'd512, 11'd512, 14'd1300, 14'd1300, 6'd20, 1'b1, 6'd20, 1'b1, 1'b1);

        // Overrun: C sampled at T+3 during A is dropped.
        frame();
        chk("overrun_cleared0", 64'(bus.overrun), 64'd0);
        push_exp(6'd5, 1'b1, 1'b0);
        launch(11'd512, 11'd512, 14'd1200, 14'd1200, 6'd5, 1'b0);
        repeat (2) begin
            @(posedge clk); #1;
        end
        launch(11'd512, 11'd512, 14'd1300, 14'd1300, 6'd30, 1'b1);
        wait_idle();
        chk("overrun_set", 64'(bus.overrun), 64'd1);
        chk("dropped_not_best", 64'(bus.best_place), 64'd5);
        frame();
        chk("overrun_cleared", 64'(bus.overrun), 64'd0);
        chk("frame_clears_valid", 64'(bus.best_valid), 64'd0);

        // Abort: frame_start sampled at T+4 of an in-flight winning candidate.
        launch(11'd512, 11'd512, 14'd1300, 14'd1300, 6'd20, 1'b1);
        repeat (3) begin
            @(posedge clk); #1;
        end
        push_exp(6'd0, 1'b0, 1'b0);
        frame();
        chk("abort_busy", 64'(bus.busy), 64'd0);
        chk("abort_best_valid", 64'(bus.best_valid), 64'd0);
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            chk("abort_no_done", 64'(bus.done), 64'd0);
        end

        // frame_start together with valid: candidate scored as first of the new frame.
        bus.frame_start = 1'b1;
        push_exp(6'd7, 1'b1, 1'b1);
        launch(11'd512, 11'd512, 14'd1200, 14'd1200, 6'd7, 1'b1);
        bus.frame_start = 1'b0;
        wait_idle();

        // Reset mid-candidate behaves like power-up reset.
        push_exp(6'd0, 1'b0, 1'b0);
        launch(11'd512, 11'd512, 14'd1200, 14'd1200, 6'd3, 1'b1);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("midrst_busy", 64'(bus.busy), 64'd0);
        chk("midrst_best_valid", 64'(bus.best_valid), 64'd0);
        chk("midrst_best_place", 64'(bus.best_place), 64'd0);
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            chk("midrst_no_done", 64'(bus.done), 64'd0);
        end

        repeat (2) @(posedge clk);
        chk("queue_empty", 64'(q.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
